// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end sharing one combinational integer ALU, with a
// single registered result slot. Define ALU_ARBITER_STATS_EN to add per-requester grant counters.
module alu_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [2*WIDTH-1:0] req_a,
   input  logic [2*WIDTH-1:0] req_b,
   input  logic [5:0]         req_op,
   input  logic [1:0]         req_alt,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WIDTH-1:0]   rsp_data,
   output logic               rsp_carry,
   output logic               rsp_zero,
   output logic               rsp_id
`ifdef ALU_ARBITER_STATS_EN
   ,
   output logic [15:0]        grant_cnt0,
   output logic [15:0]        grant_cnt1
`endif
);

   localparam int unsigned SHW = $clog2(WIDTH);

   typedef enum logic {StEmpty, StFull} state_e;

   state_e           state_q;
   logic             last_grant_q;
   logic             can_accept;
   logic             sel;
   logic             accept;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [2:0]       op;
   logic             alt;
   logic [SHW-1:0]   shamt;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] sra_res;
   logic [WIDTH-1:0] alu_res;
   logic             alu_carry;

   // Both valid: the requester not granted last time wins.
   always_comb begin
      can_accept = (state_q == StEmpty) || rsp_ready;
      sel        = req_valid[1] & (~req_valid[0] | ~last_grant_q);
      req_ready  = 2'b00;
      if (can_accept) begin
         req_ready = sel ? {req_valid[1], 1'b0} : {1'b0, req_valid[0]};
      end
      accept = |req_ready;
   end

   always_comb begin
      op_a  = sel ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
      op_b  = sel ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
      op    = sel ? req_op[5:3] : req_op[2:0];
      alt   = sel ? req_alt[1] : req_alt[0];
      shamt = op_b[SHW-1:0];
   end

   // Carry is bit WIDTH of the widened add/sub, so a SUB reports borrow.
   always_comb begin
      sum     = alt ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});
      sra_res = $signed(op_a) >>> shamt;
      alu_res = '0;
      unique case (op)
         3'b000: alu_res = sum[WIDTH-1:0];
         3'b001: alu_res = op_a << shamt;
         3'b010: alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
         3'b011: alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
         3'b100: alu_res = op_a ^ op_b;
         3'b101: alu_res = alt ? sra_res : (op_a >> shamt);
         3'b110: alu_res = op_a | op_b;
         3'b111: alu_res = op_a & op_b;
         default: alu_res = '0;
      endcase
      alu_carry = (op == 3'b000) ? sum[WIDTH] : 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StEmpty;
         last_grant_q <= 1'b1;
         rsp_data     <= '0;
         rsp_carry    <= 1'b0;
         rsp_zero     <= 1'b0;
         rsp_id       <= 1'b0;
      end else begin
         if (accept) begin
            state_q      <= StFull;
            last_grant_q <= sel;
            rsp_data     <= alu_res;
            rsp_carry    <= alu_carry;
            rsp_zero     <= (alu_res == '0);
            rsp_id       <= sel;
         end else if (rsp_ready) begin
            state_q <= StEmpty;
         end
      end
   end

   assign rsp_valid = (state_q == StFull);

`ifdef ALU_ARBITER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (accept) begin
         if (!sel && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
         if (sel && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
      end
   end
`endif

endmodule
